// File: rtl/struct_array_packer.sv
// rtl/struct_array_packer.sv - double-buffered packer of {a,b,c} entries into a flat array bus
module struct_array_packer #(
  parameter int ENTRIES = 8,
  parameter int A_W     = 1,
  parameter int B_W     = 4,
  parameter int C_W     = 2,
  parameter int ENTRY_W = A_W + B_W + C_W,
  parameter int IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1,
  parameter int COUNT_W = $clog2(ENTRIES) + 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [A_W-1:0]             in_a,
  input  logic [B_W-1:0]             in_b,
  input  logic [C_W-1:0]             in_c,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ENTRIES*ENTRY_W-1:0] out_data,
  output logic [COUNT_W-1:0]         out_count
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  logic [IDX_W-1:0]           r_wr_idx;
  logic [ENTRIES*ENTRY_W-1:0] r_acc;
  logic [COUNT_W-1:0]         r_acc_count;
  logic                       r_acc_full;
  logic [ENTRIES*ENTRY_W-1:0] r_out_data;
  logic [COUNT_W-1:0]         r_out_count;
  logic                       r_out_valid;

  logic                       w_accept;
  logic                       w_close;
  logic                       w_slot_free;
  logic [ENTRY_W-1:0]         w_entry;
  logic [ENTRIES*ENTRY_W-1:0] w_fill;
  logic [COUNT_W-1:0]         w_fill_count;

  // in_ready depends only on registered state, never on out_ready
  assign in_ready    = !r_acc_full;
  assign w_accept    = in_valid && !r_acc_full;
  assign w_slot_free = !r_out_valid || out_ready;
  assign w_entry     = {in_a, in_b, in_c};
  assign w_fill_count = COUNT_W'(r_wr_idx) + COUNT_W'(w_accept);

  // A closed array is never reopened, so flush is ignored while one is pending
  assign w_close = !r_acc_full &&
                   ((w_accept && (r_wr_idx == LAST_IDX)) ||
                    (flush && ((r_wr_idx != '0) || w_accept)));

  // Accumulator contents including the entry accepted this cycle
  always_comb begin
    w_fill = r_acc;
    if (w_accept) begin
      w_fill[ENTRY_W*r_wr_idx +: ENTRY_W] = w_entry;
    end
  end

  // Accumulator fill, close handling and output register hand-off
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_idx    <= '0;
      r_acc       <= '0;
      r_acc_count <= '0;
      r_acc_full  <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (r_acc_full) begin
        // Pending array waits for the consumer to free the output slot
        if (out_ready) begin
          r_out_data  <= r_acc;
          r_out_count <= r_acc_count;
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_wr_idx    <= '0;
          r_acc_full  <= 1'b0;
        end
      end else if (w_close) begin
        r_wr_idx <= '0;
        if (w_slot_free) begin
          r_out_data  <= w_fill;
          r_out_count <= w_fill_count;
          r_out_valid <= 1'b1;
          r_acc       <= '0;
        end else begin
          r_acc       <= w_fill;
          r_acc_count <= w_fill_count;
          r_acc_full  <= 1'b1;
        end
      end else if (w_accept) begin
        r_acc    <= w_fill;
        r_wr_idx <= r_wr_idx + 1'b1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_count = r_out_count;

endmodule
